// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
package fetch_pkg;
   localparam int XLEN        = 32;
   localparam int INSTR_W     = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               filled;
   } slot_t;
endpackage

// File: rtl/fetch_slot_buffer.sv
// Circular slot array: reserve at alloc_ptr, fill in order at fill_ptr, pop at head_ptr.
module fetch_slot_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = PW + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush_i,
   input  logic               alloc_i,
   input  logic [XLEN-1:0]    alloc_pc_i,
   input  logic               fill_i,
   input  logic [INSTR_W-1:0] fill_data_i,
   input  logic               pop_i,
   output slot_t              head_slot_o,
   output logic [CW-1:0]      used_o,
   output logic [CW-1:0]      unfilled_o
);
   slot_t         slot_q [DEPTH];
   slot_t         slot_d [DEPTH];
   logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [PW-1:0] fill_ptr_q, fill_ptr_d;
   logic [PW-1:0] head_ptr_q, head_ptr_d;
   logic [CW-1:0] used_q, used_d;
   logic [CW-1:0] filled_cnt_s;

   // Slot next state; alloc, fill and pop never target the same slot in one cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (flush_i) begin
            slot_d[i] = '0;
         end else if (fill_i && (fill_ptr_q == PW'(i))) begin
            slot_d[i] = '{pc: slot_q[i].pc, instr: fill_data_i, filled: 1'b1};
         end else if (alloc_i && (alloc_ptr_q == PW'(i))) begin
            slot_d[i] = '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
         end else if (pop_i && (head_ptr_q == PW'(i))) begin
            slot_d[i] = '0;
         end else begin
            slot_d[i] = slot_q[i];
         end
      end
   end

   // Pointer and occupancy next state.
   always_comb begin
      if (flush_i) begin
         alloc_ptr_d = '0;
         fill_ptr_d  = '0;
         head_ptr_d  = '0;
         used_d      = '0;
      end else begin
         alloc_ptr_d = alloc_i ? alloc_ptr_q + PW'(1) : alloc_ptr_q;
         fill_ptr_d  = fill_i  ? fill_ptr_q + PW'(1)  : fill_ptr_q;
         head_ptr_d  = pop_i   ? head_ptr_q + PW'(1)  : head_ptr_q;
         used_d      = used_q + CW'(alloc_i) - CW'(pop_i);
      end
   end

   // Filled slots are a subset of reserved ones, so the difference is the in-flight count.
   always_comb begin
      filled_cnt_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         filled_cnt_s = filled_cnt_s + CW'(slot_q[i].filled);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         used_q      <= '0;
      end else begin
         slot_q      <= slot_d;
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         used_q      <= used_d;
      end
   end

   assign head_slot_o = slot_q[head_ptr_q];
   assign used_o      = used_q;
   assign unfilled_o  = used_q - filled_cnt_s;
endmodule

// File: rtl/instr_prefetch_queue.sv
// Decoupled fetch stage: in-order requests to a variable-latency memory, buffered
// delivery to decode, and redirect flush that drops responses still in flight.
module instr_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = fetch_pkg::XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               mem_req_valid,
   output logic [XLEN-1:0]    mem_req_addr,
   input  logic               mem_req_ready,
   input  logic               mem_rsp_valid,
   input  logic [INSTR_W-1:0] mem_rsp_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_next_pc
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   used_s, unfilled_s;
   logic [CW:0]     occ_s;
   logic            req_fire_s, fill_s, pop_s;
   slot_t           head_s;

   assign occ_s         = {1'b0, used_s} + {1'b0, drop_q};
   assign mem_req_valid = !reset && !redirect_valid && (occ_s < (CW+1)'(DEPTH));
   assign mem_req_addr  = fetch_pc_q;
   assign req_fire_s    = mem_req_valid && mem_req_ready;
   assign fill_s        = mem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign pop_s         = head_s.filled && out_ready;

   // Fetch address and count of responses still owed for flushed requests.
   always_comb begin
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         drop_d     = drop_q + unfilled_s - CW'(mem_rsp_valid);
      end else begin
         fetch_pc_d = req_fire_s ? fetch_pc_q + XLEN'(INSTR_BYTES) : fetch_pc_q;
         if (mem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end else begin
            drop_d = drop_q;
         end
      end
   end

   // Control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   fetch_slot_buffer #(
      .DEPTH (DEPTH)
   ) u_slots (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (redirect_valid),
      .alloc_i     (req_fire_s),
      .alloc_pc_i  (fetch_pc_q),
      .fill_i      (fill_s),
      .fill_data_i (mem_rsp_data),
      .pop_i       (pop_s),
      .head_slot_o (head_s),
      .used_o      (used_s),
      .unfilled_o  (unfilled_s)
   );

   assign out_valid   = head_s.filled;
   assign out_instr   = head_s.instr;
   assign out_pc      = head_s.pc;
   assign out_next_pc = head_s.pc + XLEN'(INSTR_BYTES);
endmodule
